uart_wb_master_bridge: RTL
==========================

Name: uart_wb_master_bridge

Overview:
- Wishbone initiator driven by a UART byte stream; the counterpart of the UART Wishbone slave macro.
- Lets an external host issue 32-bit single reads and writes on a Wishbone bus through the UART pins.
- Sits between a UART RX/TX byte pair and a Wishbone slave port, e.g. a user macro or an interconnect.
- Decodes command frames, runs one classic single Wishbone cycle, and returns response bytes.

Parameters:
- TIMEOUT, 1024: cycles to wait for wbm_ack_i before aborting a bus cycle (valid range 2..65535).
- CMD_WR, 8'h57: command byte ('W') for a write.
- CMD_RD, 8'h52: command byte ('R') for a read.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data. There is no backpressure.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (at any edge with wb_rst_i=1, including mid-frame or mid-bus-cycle):
  - FSM returns to IDLE.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o, tx_valid and busy_o are 0.
  - wbm_sel_o is 4'h0; wbm_adr_o, wbm_dat_o and tx_data are 0.
  - Byte counter and timeout counter are 0.
  - Any partial frame is discarded.
- Frame formats:
  - Write: CMD_WR, A3 A2 A1 A0, D3 D2 D1 D0 (MSB first).
  - Read: CMD_RD, A3 A2 A1 A0.
- States:
  - IDLE: on rx_valid, a byte equal to CMD_WR or CMD_RD latches the op and moves to ADDR with count=0. Any other byte is ignored and the FSM stays in IDLE.
  - ADDR: each rx_valid shifts the byte into wbm_adr_o as {adr[23:0], byte} and increments count. On the 4th byte, a write goes to DATA (count=0) and a read goes to BUS.
  - DATA: the same shifting into wbm_dat_o. On the 4th byte, go to BUS.
  - BUS:
    - Assert cyc=stb=1, sel=4'hF, we = (op == write).
    - Hold all bus outputs stable until ack or timeout.
    - Timeout counter increments every cycle in BUS.
    - If ack and timeout occur in the same cycle, ack wins.
    - On wbm_ack_i=1: deassert cyc/stb/we on the next edge. For a read, capture wbm_dat_i into a shift register. Go to RESP.
    - If the counter reaches TIMEOUT-1 without ack: deassert cyc/stb and go to RESP with status error.
  - RESP: present response bytes one at a time on tx_data with tx_valid=1. Advance only on tx_valid && tx_ready. After the last byte is accepted, tx_valid=0 and the FSM returns to IDLE.
- Response bytes:
  - Write success: 8'h4B ('K').
  - Read success: D3 D2 D1 D0, MSB first.
  - Any timeout: single byte 8'h45 ('E').
- Latency:
  - cyc/stb rise on the edge after the last frame byte is sampled.
  - The first response byte is valid on the edge after ack is sampled.
- rx_valid while in BUS or RESP: the byte is dropped, with no effect on state or outputs.
- tx_data and tx_valid hold stable while tx_valid && !tx_ready.
- No inter-byte timeout: a partial frame waits indefinitely until completed or reset.
- wbm_adr_o and wbm_dat_o retain their last values in IDLE. Only cyc/stb/we return to 0.

Test Plan:
- Write: reset, then bytes 57 30 00 00 00 DE AD BE EF, slave acks 2 cycles after stb -> one cycle with adr=32'h3000_0000, dat=32'hDEAD_BEEF, we=1, sel=F; cyc/stb low after ack; single tx byte 4B; busy_o then 0.
- Read: bytes 52 30 00 00 04, slave returns 32'h1234_5678 with ack -> we=0, adr=32'h3000_0004; tx bytes 12 34 56 78 in order.
- Backpressure: same read with tx_ready low for 5 cycles per byte -> tx_data/tx_valid stable while stalled; exactly 4 bytes transferred with no duplicates.
- Timeout: TIMEOUT=16, write frame, slave never acks -> cyc/stb high for exactly 16 cycles, then low; single tx byte 45; FSM returns to IDLE.
- Robustness:
  - Bytes 00 FF 52 30 00 00 08 -> leading 00 and FF ignored; read to 32'h3000_0008.
  - Bytes injected during BUS -> dropped; the next frame decodes correctly.
- Reset mid-operation:
  - Assert wb_rst_i while cyc=1 -> cyc/stb/we/tx_valid all 0 on the next edge.
  - A subsequent full read frame completes normally.

Source files
------------

// File: rtl/uart_wb_master_bridge.sv
// UART-byte-stream to Wishbone initiator: decodes 'W'/'R' frames, runs one classic
// single Wishbone cycle with an ack timeout, and streams the response bytes back.
module uart_wb_master_bridge #(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RSP_OK   = 8'h4B;
    localparam logic [7:0]  RSP_ERR  = 8'h45;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_wr;
    logic        r_err;
    logic [1:0]  r_cnt;
    logic [1:0]  r_tx_cnt;
    logic [15:0] r_tmo;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rd;

    logic w_is_cmd;
    logic w_tmo_hit;
    logic w_tx_fire;
    logic w_tx_last;

    assign w_is_cmd  = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_tx_fire = tx_valid && tx_ready;
    // Errors and write acks are a single byte; read data is four.
    assign w_tx_last = (r_err || r_is_wr) ? 1'b1 : (r_tx_cnt == 2'd3);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_next    = r_state;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy_o    = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: if (rx_valid && w_is_cmd) w_next = S_ADDR;
            S_ADDR: if (rx_valid && r_cnt == 2'd3) w_next = r_is_wr ? S_DATA : S_BUS;
            S_DATA: if (rx_valid && r_cnt == 2'd3) w_next = S_BUS;
            S_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = r_is_wr;
                wbm_sel_o = 4'hF;
                if (wbm_ack_i || w_tmo_hit) w_next = S_RESP;
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = r_err ? RSP_ERR : (r_is_wr ? RSP_OK : r_rd[31:24]);
                if (w_tx_fire && w_tx_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_is_wr  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 2'd0;
            r_tx_cnt <= 2'd0;
            r_tmo    <= 16'd0;
            r_adr    <= 32'd0;
            r_dat    <= 32'd0;
            r_rd     <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tmo    <= 16'd0;
                    r_tx_cnt <= 2'd0;
                    if (rx_valid && w_is_cmd) begin
                        r_is_wr <= (rx_data == CMD_WR);
                        r_err   <= 1'b0;
                        r_cnt   <= 2'd0;
                    end
                end
                S_ADDR: if (rx_valid) begin
                    r_adr <= {r_adr[23:0], rx_data};
                    r_cnt <= r_cnt + 2'd1;
                end
                S_DATA: if (rx_valid) begin
                    r_dat <= {r_dat[23:0], rx_data};
                    r_cnt <= r_cnt + 2'd1;
                end
                S_BUS: begin
                    r_tmo    <= r_tmo + 16'd1;
                    r_tx_cnt <= 2'd0;
                    // Ack takes priority over a coincident timeout.
                    if (wbm_ack_i) begin
                        if (!r_is_wr) r_rd <= wbm_dat_i;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: if (w_tx_fire) begin
                    r_rd     <= {r_rd[23:0], 8'h00};
                    r_tx_cnt <= r_tx_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

endmodule
